// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm
//
// Multi-cycle instruction sequencer for the CoreBassier datapath. Every
// instruction walks FETCH -> DECODE -> EXEC and then, depending on its class,
// MEM, IO_WAIT, WB or HALT before returning to FETCH. Decode fields are
// registered at the DECODE edge and held until the next DECODE.
//
// Ports
//   clock, reset       posedge clock, synchronous active-high reset
//   opcode             instruction register opcode field, sampled in DECODE
//   alu_done           multi-cycle ALU result valid (EXEC)
//   mem_ready          data memory access complete (MEM)
//   in_valid           input port has data (IO_WAIT, In)
//   out_ready          output port accepts data (IO_WAIT, Out)
//   resume             leave HALT
//   ir_write, pc_write FETCH strobes
//   aluCode, targetRegister, aluSource, memoryToRegister
//                      registered decode fields
//   branch, writeRegister
//                      single-cycle strobes (EXEC of branches, WB)
//   memoryRead, memoryWrite, in_ready, out_valid
//                      levels held while waiting on the matching handshake
//   halt               high while in HALT
//   illegal_op         sticky: an undefined opcode was decoded
//   alu_timeout        sticky: a multi-cycle ALU op never signalled done
//   state              FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 IO_WAIT=5 HALT=6
//
// Handshake semantics: a request level (memoryRead/memoryWrite, in_ready,
// out_valid, or the EXEC wait on a multi-cycle op) is held for as long as the
// FSM sits in the waiting state. The partner's completion signal
// (mem_ready, in_valid, out_ready, alu_done) is only looked at while that
// request is up; a completion seen on the first waiting cycle is a legal
// single-cycle transfer, and the transfer completes at that rising edge.
// Completion signals outside their waiting state are ignored.
// ---------------------------------------------------------------------------
module control_fsm #(
    parameter int OPCODE_W = 6,
    parameter int ALU_W    = 6,
    parameter int MTR_W    = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_done,
    input  logic                mem_ready,
    input  logic                in_valid,
    input  logic                out_ready,
    input  logic                resume,
    output logic                ir_write,
    output logic                pc_write,
    output logic [ALU_W-1:0]    aluCode,
    output logic                targetRegister,
    output logic                aluSource,
    output logic [MTR_W-1:0]    memoryToRegister,
    output logic                branch,
    output logic                writeRegister,
    output logic                memoryRead,
    output logic                memoryWrite,
    output logic                in_ready,
    output logic                out_valid,
    output logic                halt,
    output logic                illegal_op,
    output logic                alu_timeout,
    output logic [2:0]          state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_LOAD  = 6'b010100;
    localparam logic [5:0] OP_STORE = 6'b010101;
    localparam logic [5:0] OP_JUMP  = 6'b010110;
    localparam logic [5:0] OP_BEQ   = 6'b010111;
    localparam logic [5:0] OP_BNE   = 6'b011000;
    localparam logic [5:0] OP_NOP   = 6'b011001;
    localparam logic [5:0] OP_HALT  = 6'b011010;
    localparam logic [5:0] OP_IN    = 6'b011011;
    localparam logic [5:0] OP_OUT   = 6'b011100;
    localparam logic [5:0] OP_MOV   = 6'b011101;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_IO_WAIT = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    // Instruction class decides the path taken after DECODE.
    typedef enum logic [3:0] {
        C_NOP    = 4'd0,
        C_ALU    = 4'd1,
        C_MULTI  = 4'd2,
        C_LOAD   = 4'd3,
        C_STORE  = 4'd4,
        C_IN     = 4'd5,
        C_OUT    = 4'd6,
        C_BRANCH = 4'd7,
        C_HALT   = 4'd8
    } class_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t             state_q,       state_d;
    class_t             class_q,       class_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [ALU_W-1:0]   alu_code_q,    alu_code_d;
    logic               target_reg_q,  target_reg_d;
    logic               alu_source_q,  alu_source_d;
    logic [MTR_W-1:0]   mem_to_reg_q,  mem_to_reg_d;
    logic               illegal_q,     illegal_d;
    logic               timeout_q,     timeout_d;
    // High for the cycle after a reset edge: FETCH is parked with its
    // strobes suppressed so every output reads zero in that cycle.
    logic               rst_hold_q,    rst_hold_d;

    // -----------------------------------------------------------------------
    // Opcode decode (combinational, captured at the DECODE edge)
    // -----------------------------------------------------------------------
    logic [31:0]        op_ext;
    logic [5:0]         op6;
    logic               upper_nz;
    class_t             dec_class;
    logic [ALU_W-1:0]   dec_alu;
    logic               dec_tr;
    logic               dec_asrc;
    logic [MTR_W-1:0]   dec_mtr;
    logic               dec_illegal;

    always_comb begin
        op_ext   = 32'(opcode);
        op6      = op_ext[5:0];
        upper_nz = |op_ext[31:6];

        // Anything not matched below is an illegal opcode, executed as Nop.
        dec_class   = C_NOP;
        dec_alu     = ALU_W'(OP_NOP);
        dec_tr      = 1'b0;
        dec_asrc    = 1'b0;
        dec_mtr     = '0;
        dec_illegal = 1'b1;

        if (!upper_nz) begin
            case (op6)
                // Register-operand ALU ops
                6'b000000, 6'b000010, 6'b000100, 6'b000110,
                6'b001000, 6'b001001, 6'b001011, 6'b001101,
                6'b001111, 6'b010000, 6'b010001, 6'b010010: begin
                    dec_alu     = ALU_W'(op6);
                    dec_tr      = 1'b1;
                    dec_illegal = 1'b0;
                end
                // Immediate-operand ALU ops
                6'b000001, 6'b000011, 6'b000101, 6'b000111,
                6'b001010, 6'b001100, 6'b001110, 6'b010011: begin
                    dec_alu     = ALU_W'(op6);
                    dec_tr      = 1'b1;
                    dec_asrc    = 1'b1;
                    dec_illegal = 1'b0;
                end
                OP_LOAD, OP_STORE: begin
                    dec_alu     = '0;
                    dec_asrc    = 1'b1;
                    dec_mtr     = MTR_W'(1);
                    dec_illegal = 1'b0;
                end
                OP_IN: begin
                    dec_alu     = ALU_W'(op6);
                    dec_mtr     = MTR_W'(2);
                    dec_illegal = 1'b0;
                end
                OP_MOV, OP_JUMP, OP_BEQ, OP_BNE, OP_NOP, OP_HALT, OP_OUT: begin
                    dec_alu     = ALU_W'(op6);
                    dec_illegal = 1'b0;
                end
                default: begin
                end
            endcase

            case (op6)
                // Mult, Multi, Div, Divi, Mod wait on alu_done
                6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b001000:
                    dec_class = C_MULTI;
                6'b000000, 6'b000001, 6'b000010, 6'b000011,
                6'b001001, 6'b001010, 6'b001011, 6'b001100,
                6'b001101, 6'b001110, 6'b001111, 6'b010000,
                6'b010001, 6'b010010, 6'b010011, OP_MOV:
                    dec_class = C_ALU;
                OP_LOAD:                   dec_class = C_LOAD;
                OP_STORE:                  dec_class = C_STORE;
                OP_IN:                     dec_class = C_IN;
                OP_OUT:                    dec_class = C_OUT;
                OP_JUMP, OP_BEQ, OP_BNE:   dec_class = C_BRANCH;
                OP_HALT:                   dec_class = C_HALT;
                default:                   dec_class = C_NOP;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        cnt_d        = cnt_q;
        alu_code_d   = alu_code_q;
        target_reg_d = target_reg_q;
        alu_source_d = alu_source_q;
        mem_to_reg_d = mem_to_reg_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        rst_hold_d   = 1'b0;

        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        writeRegister = 1'b0;
        memoryRead    = 1'b0;
        memoryWrite   = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        halt          = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (!rst_hold_q) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                class_d      = dec_class;
                alu_code_d   = dec_alu;
                target_reg_d = dec_tr;
                alu_source_d = dec_asrc;
                mem_to_reg_d = dec_mtr;
                illegal_d    = illegal_q | dec_illegal;
                // The first EXEC cycle is cycle 1 of the ALU wait.
                cnt_d        = CNT_W'(1);
                state_d      = S_EXEC;
            end

            S_EXEC: begin
                case (class_q)
                    C_ALU:   state_d = S_WB;
                    C_MULTI: begin
                        // Done on the TIMEOUT-th cycle still wins over timeout.
                        if (alu_done) begin
                            state_d = S_WB;
                        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                            timeout_d = 1'b1;
                            state_d   = S_FETCH;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    C_BRANCH: begin
                        branch  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_IN, C_OUT:     state_d = S_IO_WAIT;
                    C_HALT:          state_d = S_HALT;
                    default:         state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                if (class_q == C_LOAD) begin
                    memoryRead = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else begin
                    memoryWrite = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
            end

            S_IO_WAIT: begin
                if (class_q == C_IN) begin
                    in_ready = 1'b1;
                    if (in_valid) state_d = S_WB;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) state_d = S_FETCH;
                end
            end

            S_WB: begin
                writeRegister = 1'b1;
                state_d       = S_FETCH;
            end

            S_HALT: begin
                halt = 1'b1;
                if (resume) state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_FETCH;
            class_q      <= C_NOP;
            cnt_q        <= '0;
            alu_code_q   <= '0;
            target_reg_q <= 1'b0;
            alu_source_q <= 1'b0;
            mem_to_reg_q <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            class_q      <= class_d;
            cnt_q        <= cnt_d;
            alu_code_q   <= alu_code_d;
            target_reg_q <= target_reg_d;
            alu_source_q <= alu_source_d;
            mem_to_reg_q <= mem_to_reg_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            rst_hold_q   <= rst_hold_d;
        end
    end

    assign aluCode          = alu_code_q;
    assign targetRegister   = target_reg_q;
    assign aluSource        = alu_source_q;
    assign memoryToRegister = mem_to_reg_q;
    assign illegal_op       = illegal_q;
    assign alu_timeout      = timeout_q;
    assign state            = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm. Instructions are planned ahead as a queue of
// per-cycle records (inputs to drive, outputs expected) derived from the
// instruction-level rules: each class expands to its fixed sequence of
// phases with handshake waits of a chosen length. One process replays the
// queue, checking every output every cycle.
module tb_control_fsm;

  localparam int TIMEOUT = 4;

  localparam int K_NOP = 0, K_ALU = 1, K_MUL = 2, K_LD = 3, K_ST = 4;
  localparam int K_IN = 5, K_OUT = 6, K_BR = 7, K_HLT = 8;
  localparam int NEVER = 99;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       alu_done = 1'b0, mem_ready = 1'b0, in_valid = 1'b0;
  logic       out_ready = 1'b0, resume = 1'b0;
  logic       ir_write, pc_write, targetRegister, aluSource, branch;
  logic       writeRegister, memoryRead, memoryWrite, in_ready, out_valid;
  logic       halt, illegal_op, alu_timeout;
  logic [5:0] aluCode;
  logic [2:0] memoryToRegister, state;

  always #5 clock = ~clock;

  control_fsm #(.OPCODE_W(6), .ALU_W(6), .MTR_W(3), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .alu_done(alu_done),
    .mem_ready(mem_ready), .in_valid(in_valid), .out_ready(out_ready),
    .resume(resume), .ir_write(ir_write), .pc_write(pc_write),
    .aluCode(aluCode), .targetRegister(targetRegister), .aluSource(aluSource),
    .memoryToRegister(memoryToRegister), .branch(branch),
    .writeRegister(writeRegister), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .in_ready(in_ready), .out_valid(out_valid),
    .halt(halt), .illegal_op(illegal_op), .alu_timeout(alu_timeout),
    .state(state)
  );

  // ---------------- plan records ----------------
  typedef struct {
    logic [5:0] op;
    logic       rst, ad, mrdy, iv, ordy, res;
    logic       chk;
    logic [2:0] st;
    logic       irw, pcw, br, wr, mrd, mwr, inr, outv, hlt;
    logic [5:0] alu;
    logic       tr, asrc;
    logic [2:0] mtr;
    logic       ill, tmo;
  } cyc_t;

  cyc_t plan_q[$];
  cyc_t cur;

  // architectural view of the registered decode fields and sticky flags
  logic [5:0] m_alu;
  logic       m_tr, m_asrc, m_ill, m_tmo;
  logic [2:0] m_mtr;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ir_cyc[$];

  task automatic model_reset();
    m_alu = '0; m_tr = 1'b0; m_asrc = 1'b0; m_mtr = '0;
    m_ill = 1'b0; m_tmo = 1'b0;
  endtask

  // Start a cycle record: random don't-care inputs, all strobes low.
  task automatic new_cyc(input logic [2:0] st);
    cur.op   = 6'($urandom_range(0, 63));
    cur.rst  = 1'b0;
    cur.ad   = 1'($urandom_range(0, 1));
    cur.mrdy = 1'($urandom_range(0, 1));
    cur.iv   = 1'($urandom_range(0, 1));
    cur.ordy = 1'($urandom_range(0, 1));
    cur.res  = 1'($urandom_range(0, 1));
    cur.chk  = 1'b1;
    cur.st   = st;
    cur.irw = 0; cur.pcw = 0; cur.br = 0; cur.wr = 0; cur.mrd = 0;
    cur.mwr = 0; cur.inr = 0; cur.outv = 0; cur.hlt = 0;
    cur.alu = m_alu; cur.tr = m_tr; cur.asrc = m_asrc; cur.mtr = m_mtr;
    cur.ill = m_ill; cur.tmo = m_tmo;
  endtask

  task automatic emit();
    plan_q.push_back(cur);
  endtask

  // ISA table: class and decode fields of a 6-bit opcode.
  function automatic void dec(input logic [5:0] op, output int k,
                              output logic [5:0] alu, output logic tr,
                              output logic asrc, output logic [2:0] mtr,
                              output logic ill);
    k = K_NOP; alu = 6'd25; tr = 0; asrc = 0; mtr = 0; ill = 1;
    if (op <= 6'd19) begin
      ill = 0; alu = op; tr = 1;
      asrc = (op inside {6'd1, 6'd3, 6'd5, 6'd7, 6'd10, 6'd12, 6'd14, 6'd19});
      k = (op inside {[6'd4:6'd8]}) ? K_MUL : K_ALU;
    end else if (op <= 6'd29) begin
      ill = 0; alu = op;
      case (op)
        6'd20: begin k = K_LD; alu = 0; asrc = 1; mtr = 1; end
        6'd21: begin k = K_ST; alu = 0; asrc = 1; mtr = 1; end
        6'd22, 6'd23, 6'd24: k = K_BR;
        6'd25: k = K_NOP;
        6'd26: k = K_HLT;
        6'd27: begin k = K_IN; mtr = 2; end
        6'd28: k = K_OUT;
        default: k = K_ALU;  // Mov
      endcase
    end
  endfunction

  task automatic wb();
    new_cyc(3'd4); cur.wr = 1; emit();
  endtask

  // Plan one instruction. d = handshake wait cycles before completion
  // (NEVER for an ALU op that never finishes). abort_at >= 0 asserts reset
  // in that IO_WAIT cycle of an In.
  task automatic plan_instr(input logic [5:0] op, input int d, input int abort_at);
    int k; logic [5:0] a; logic t, s, il; logic [2:0] m;
    dec(op, k, a, t, s, m, il);
    new_cyc(3'd0); cur.irw = 1; cur.pcw = 1; emit();
    new_cyc(3'd1); cur.op = op; emit();
    m_alu = a; m_tr = t; m_asrc = s; m_mtr = m; m_ill = m_ill | il;
    case (k)
      K_ALU: begin new_cyc(3'd2); emit(); wb(); end
      K_MUL: begin
        if (d + 1 <= TIMEOUT) begin
          for (int i = 1; i <= d + 1; i++) begin
            new_cyc(3'd2); cur.ad = (i == d + 1); emit();
          end
          wb();
        end else begin
          for (int i = 1; i <= TIMEOUT; i++) begin
            new_cyc(3'd2); cur.ad = 0; emit();
          end
          m_tmo = 1;
        end
      end
      K_LD, K_ST: begin
        new_cyc(3'd2); emit();
        for (int i = 0; i <= d; i++) begin
          new_cyc(3'd3); cur.mrd = (k == K_LD); cur.mwr = (k == K_ST);
          cur.mrdy = (i == d); emit();
        end
        if (k == K_LD) wb();
      end
      K_IN: begin
        new_cyc(3'd2); emit();
        for (int i = 0; i <= d; i++) begin
          new_cyc(3'd5); cur.inr = 1; cur.iv = (i == d);
          if (i == abort_at) begin
            cur.iv = 0; cur.rst = 1; emit();
            model_reset();
            new_cyc(3'd0); emit();
            return;
          end
          emit();
        end
        wb();
      end
      K_OUT: begin
        new_cyc(3'd2); emit();
        for (int i = 0; i <= d; i++) begin
          new_cyc(3'd5); cur.outv = 1; cur.ordy = (i == d); emit();
        end
      end
      K_BR: begin new_cyc(3'd2); cur.br = 1; emit(); end
      K_HLT: begin
        new_cyc(3'd2); emit();
        for (int i = 0; i <= d; i++) begin
          new_cyc(3'd6); cur.hlt = 1; cur.res = (i == d); emit();
        end
      end
      default: begin new_cyc(3'd2); emit(); end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin
    cyc_t r;
    int len_exp[9];
    len_exp = '{4, 4, 6, 7, 4, 6, 14, 3, 10};

    // reset, then the post-reset cycle with every output low
    model_reset();
    new_cyc(3'd0); cur.rst = 1; cur.chk = 0; emit();
    new_cyc(3'd0); emit();

    plan_instr(6'd0,  0, -1);       // Add
    plan_instr(6'd1,  0, -1);       // Addi
    plan_instr(6'd5,  2, -1);       // Multi, done in 3rd EXEC cycle
    plan_instr(6'd20, 2, -1);       // Load, 2 wait cycles
    plan_instr(6'd21, 0, -1);       // Store, immediate
    plan_instr(6'd6,  NEVER, -1);   // Div, times out
    plan_instr(6'd26, 10, -1);      // Halt, resume after 10 cycles
    plan_instr(6'd63, 0, -1);       // illegal
    plan_instr(6'd27, 5, -1);       // In, in_valid after 5 cycles
    plan_instr(6'd27, 9, 2);        // In aborted by reset
    plan_instr(6'd4,  TIMEOUT - 1, -1); // Mult done on the TIMEOUT-th cycle
    plan_instr(6'd28, 2, -1);       // Out
    plan_instr(6'd22, 0, -1);       // Jump
    plan_instr(6'd29, 0, -1);       // Mov
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 7) op = 6'($urandom_range(0, 29));
      else op = 6'($urandom_range(30, 63));
      plan_instr(op, int'($urandom_range(0, 5)), -1);
    end

    // replay: check this cycle's outputs, then drive this cycle's inputs
    while (plan_q.size() > 0) begin
      @(negedge clock);
      r = plan_q.pop_front();
      if (r.chk) begin
        chk("state",            32'(state),            32'(r.st));
        chk("ir_write",         32'(ir_write),         32'(r.irw));
        chk("pc_write",         32'(pc_write),         32'(r.pcw));
        chk("branch",           32'(branch),           32'(r.br));
        chk("writeRegister",    32'(writeRegister),    32'(r.wr));
        chk("memoryRead",       32'(memoryRead),       32'(r.mrd));
        chk("memoryWrite",      32'(memoryWrite),      32'(r.mwr));
        chk("in_ready",         32'(in_ready),         32'(r.inr));
        chk("out_valid",        32'(out_valid),        32'(r.outv));
        chk("halt",             32'(halt),             32'(r.hlt));
        chk("aluCode",          32'(aluCode),          32'(r.alu));
        chk("targetRegister",   32'(targetRegister),   32'(r.tr));
        chk("aluSource",        32'(aluSource),        32'(r.asrc));
        chk("memoryToRegister", 32'(memoryToRegister), 32'(r.mtr));
        chk("illegal_op",       32'(illegal_op),       32'(r.ill));
        chk("alu_timeout",      32'(alu_timeout),      32'(r.tmo));
      end
      if (ir_write === 1'b1) ir_cyc.push_back(cyc);
      reset     = r.rst;
      opcode    = r.op;
      alu_done  = r.ad;
      mem_ready = r.mrdy;
      in_valid  = r.iv;
      out_ready = r.ordy;
      resume    = r.res;
      cyc++;
    end

    // hand-computed instruction lengths of the first nine directed ops
    for (int i = 0; i < 9; i++) begin
      if (i + 1 < ir_cyc.size())
        chk("instr_len", 32'(ir_cyc[i + 1] - ir_cyc[i]), 32'(len_exp[i]));
      else
        chk("instr_len", 32'(0), 32'(len_exp[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode decoder for the CoreBassier datapath.
- Sequences every instruction through fetch, decode, execute, memory, writeback and I/O states.
- Stalls on handshakes from the ALU, data memory and I/O ports; resumes from halt on command; flags illegal opcodes and ALU timeouts.
- Sits between the instruction register/PC and the datapath muxes, register file, memory and I/O.

Parameters:
OPCODE_W, 6, opcode width; ISA encodings occupy the low 6 bits, upper bits must be 0 for a legal op
ALU_W, 6, aluCode width; opcode zero-extended or truncated into it
MTR_W, 3, memoryToRegister width
TIMEOUT, 64, max EXEC wait cycles for alu_done (>=2); counter width clog2(TIMEOUT+1)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  opcode field of the instruction register, sampled in DECODE
alu_done  in  1  multi-cycle ALU result valid
mem_ready  in  1  data memory access complete
in_valid  in  1  input port has data
out_ready  in  1  output port accepts data
resume  in  1  leave HALT
ir_write  out  1  strobe: load instruction register
pc_write  out  1  strobe: PC increment
aluCode  out  ALU_W  registered ALU operation
targetRegister  out  1  registered destination select
aluSource  out  1  registered, 1 = immediate operand
memoryToRegister  out  MTR_W  registered writeback source: 0 ALU, 1 memory, 2 input port
branch  out  1  strobe: branch/jump resolve
writeRegister  out  1  strobe: register file write
memoryRead  out  1  level: held during MEM for loads
memoryWrite  out  1  level: held during MEM for stores
in_ready  out  1  level: held in IO_WAIT for In
out_valid  out  1  level: held in IO_WAIT for Out
halt  out  1  high in HALT state
illegal_op  out  1  sticky, cleared only by reset
alu_timeout  out  1  sticky, cleared only by reset
state  out  3  encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, IO_WAIT=5, HALT=6

Behaviour:
- Reset: sampled high at posedge sets state=FETCH and zeroes every output, including sticky flags and the timeout counter. Reset wins over every other input and aborts any in-flight instruction. Strobes are low in the cycle after reset is sampled.
- FETCH, 1 cycle: ir_write=1, pc_write=1, then DECODE.
- DECODE, 1 cycle: register aluCode, targetRegister, aluSource and memoryToRegister per opcode class; these hold until the next DECODE. Then EXEC.
- Register ALU ops (000000,000010,000100,000110,001000,001001,001011,001101,001111,010000,010001,010010): aluCode=opcode, targetRegister=1, aluSource=0, memoryToRegister=0.
- Immediate ALU ops (000001,000011,000101,000111,001010,001100,001110,010011): same as register ops except aluSource=1.
- Load 010100 / Store 010101: aluCode=0, targetRegister=0, aluSource=1, memoryToRegister=1.
- In 011011: memoryToRegister=2. Mov 011101: memoryToRegister=0. Jump 010110, Beq 010111, Bne 011000, Nop 011001, Halt 011010, Out 011100: aluCode=opcode, other registered decode outputs 0.
- Illegal opcode (any other code, or nonzero upper bits): decoded as Nop, illegal_op set at the DECODE edge.
- EXEC, single-cycle ALU ops and Mov: 1 cycle, then WB.
- EXEC, multi-cycle ops (Mult 000100/000101, Div 000110/000111, Mod 001000): stay while alu_done=0, counting cycles from 1. alu_done=1 goes to WB that cycle. If the count reaches TIMEOUT with no done: set alu_timeout, go to FETCH, no writeback. alu_done in the TIMEOUT-th cycle counts as done.
- EXEC, Jump/Beq/Bne: branch=1 for 1 cycle, then FETCH.
- EXEC, Nop/illegal: go to FETCH.
- EXEC, Load/Store: go to MEM. In/Out: go to IO_WAIT. Halt: go to HALT.
- MEM: memoryRead (load) or memoryWrite (store) high until mem_ready. mem_ready in the first MEM cycle is a legal 1-cycle access. Load then goes to WB; store goes to FETCH.
- IO_WAIT: In raises in_ready until in_valid, then WB. Out raises out_valid until out_ready, then FETCH.
- WB: writeRegister=1 for 1 cycle, then FETCH.
- HALT: halt=1; stays while resume=0. resume=1 goes to FETCH next edge with halt=0. resume outside HALT is ignored.
- Latency, zero-wait handshakes:
  - ALU op / Mov: 4 cycles.
  - Load, In: 5 cycles.
  - Store, Out: 4 cycles.
  - Branch, Jump, Nop: 3 cycles.
- Strobes never overlap. At most one of writeRegister, memoryRead, memoryWrite, branch, in_ready, out_valid is high per cycle.

Test Plan:
- Reset, then Add 000000 with no stalls -> ir_write cycle 1, writeRegister only in cycle 4, aluCode=0, targetRegister=1, aluSource=0; back to FETCH in cycle 5.
- Addi, then Multi 000101 with alu_done at 3rd EXEC cycle -> aluSource=1; EXEC lasts 3 cycles, 6-cycle instruction, single writeRegister pulse.
- Load with mem_ready low 2 cycles, then Store with mem_ready immediate -> memoryRead high 3 cycles, memoryToRegister=1, then WB. Store: memoryWrite high 1 cycle, no writeRegister.
- Div with alu_done never asserted, TIMEOUT=4 -> 4 EXEC cycles, alu_timeout=1 sticky, no writeRegister, next FETCH; reset clears flag.
- Halt 011010, resume held 0 for 10 cycles then 1 -> halt=1 from cycle 4 through the resume edge, then FETCH. Opcode 111111 -> illegal_op=1, 3-cycle Nop.
- In with in_valid after 5 cycles; reset asserted mid IO_WAIT on a second In -> first: memoryToRegister=2, in_ready high 6 cycles, then WB. Second: all outputs 0 and state=FETCH after the reset edge, no writeRegister.
